mem_port_arbiter: RTL and testbench

Shares one synchronous single-port 32-bit SRAM between three requesters: the core data port, the core instruction-fetch port, and an external loader/debug port. It sits between the core's MMU-facing ports and the on-chip memory. It grants at most one access per cycle and routes the one-cycle-latency read data back to the granted requester. It also provides a starvation guard so the loader always makes progress.

---
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports and the SRAM port of mem_port_arbiter.
// The master modport is the requester/memory side, the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 12
);
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic          dm_err;

  logic          im_req;
  logic [31:0]   im_addr;
  logic          im_gnt;
  logic          im_rvalid;
  logic          im_err;

  logic          ext_req;
  logic          ext_we;
  logic [31:0]   ext_addr;
  logic [31:0]   ext_wdata;
  logic [3:0]    ext_be;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic          ext_err;

  logic [31:0]   rdata;

  logic          sram_en;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_gnt, dm_rvalid, dm_err,
    input  im_req, im_addr,
    output im_gnt, im_rvalid, im_err,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_be,
    output ext_gnt, ext_rvalid, ext_err,
    output rdata,
    output sram_en, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_gnt, dm_rvalid, dm_err,
    output im_req, im_addr,
    input  im_gnt, im_rvalid, im_err,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_be,
    input  ext_gnt, ext_rvalid, ext_err,
    input  rdata,
    input  sram_en, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter onto one single-port 32-bit SRAM (data > fetch > loader),
// with a starvation guard that periodically hands the loader top priority.
module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetb,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_DM,
    PORT_IM,
    PORT_EXT
  } port_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  port_e       win;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_we;
  logic        acc_err;
  logic        acc_ok;
  logic        wr_eff;
  logic        forced;

  port_e       resp_port_q, resp_port_d;
  logic        resp_err_q,  resp_err_d;
  logic        resp_rd_q,   resp_rd_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  assign forced = (starve_cnt_q == STARVE_LIM);

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    win = PORT_NONE;
    if (resetb) begin
      if (forced && bus.ext_req) win = PORT_EXT;
      else if (bus.dm_req)       win = PORT_DM;
      else if (bus.im_req)       win = PORT_IM;
      else if (bus.ext_req)      win = PORT_EXT;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    case (win)
      PORT_DM: begin
        sel_addr  = bus.dm_addr;
        sel_wdata = bus.dm_wdata;
        sel_be    = bus.dm_be;
        sel_we    = bus.dm_we;
      end
      PORT_IM: begin
        sel_addr  = bus.im_addr;
      end
      PORT_EXT: begin
        sel_addr  = bus.ext_addr;
        sel_wdata = bus.ext_wdata;
        sel_be    = bus.ext_be;
        sel_we    = bus.ext_we;
      end
      default: ;
    endcase
  end

  // Out-of-range or misaligned accesses still take the slot but never reach the SRAM.
  assign acc_err = (win != PORT_NONE) && ((|sel_addr[31:AW+2]) || (|sel_addr[1:0]));
  assign acc_ok  = (win != PORT_NONE) && !acc_err;
  assign wr_eff  = sel_we && (sel_be != 4'b0000);

  assign bus.dm_gnt  = (win == PORT_DM);
  assign bus.im_gnt  = (win == PORT_IM);
  assign bus.ext_gnt = (win == PORT_EXT);

  assign bus.sram_en    = acc_ok;
  assign bus.sram_we    = acc_ok && wr_eff;
  assign bus.sram_be    = (acc_ok && wr_eff) ? sel_be : 4'b0000;
  assign bus.sram_addr  = acc_ok ? sel_addr[AW+1:2] : '0;
  assign bus.sram_wdata = (acc_ok && wr_eff) ? sel_wdata : '0;

  always_comb begin
    resp_port_d = win;
    resp_err_d  = acc_err;
    resp_rd_d   = acc_ok && !wr_eff;
    starve_cnt_d = '0;
    if (bus.ext_req && (win != PORT_EXT)) begin
      starve_cnt_d = forced ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      resp_port_q  <= PORT_NONE;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      resp_port_q  <= resp_port_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read data is only passed through for error-free reads; write acks return zero.
  assign bus.dm_rvalid  = (resp_port_q == PORT_DM);
  assign bus.im_rvalid  = (resp_port_q == PORT_IM);
  assign bus.ext_rvalid = (resp_port_q == PORT_EXT);
  assign bus.dm_err     = bus.dm_rvalid  && resp_err_q;
  assign bus.im_err     = bus.im_rvalid  && resp_err_q;
  assign bus.ext_err    = bus.ext_rvalid && resp_err_q;
  assign bus.rdata      = resp_rd_q ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for starvation
// and mid-access reset, then randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int AW    = 12;
  localparam int SMAX  = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  // Memory behind the arbiter: registers the access and returns read data next cycle.
  logic [31:0] sram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we && bus.sram_be[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: ports numbered 0 none, 1 dm, 2 im, 3 ext.
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_starve;
  int          m_pend;
  bit          m_pend_err;
  logic [31:0] m_pend_data;
  int          e_win;
  bit          e_err, e_wr, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic model_eval();
    e_win = 0;
    if (resetb) begin
      if (m_starve == SMAX && bus.ext_req) e_win = 3;
      else if (bus.dm_req)                 e_win = 1;
      else if (bus.im_req)                 e_win = 2;
      else if (bus.ext_req)                e_win = 3;
    end
    e_addr = 0; e_wdata = 0; e_be = 0; e_we = 0;
    if (e_win == 1) begin e_addr = bus.dm_addr; e_wdata = bus.dm_wdata; e_be = bus.dm_be; e_we = bus.dm_we; end
    if (e_win == 2) begin e_addr = bus.im_addr; end
    if (e_win == 3) begin e_addr = bus.ext_addr; e_wdata = bus.ext_wdata; e_be = bus.ext_be; e_we = bus.ext_we; end
    e_err = (e_win != 0) && (((e_addr >> (AW + 2)) != 0) || ((e_addr % 4) != 0));
    e_wr  = (e_win != 0) && !e_err && e_we && (e_be != 0);
  endtask

  task automatic model_check();
    bit          en;
    logic [31:0] exp_addr;
    en       = (e_win != 0) && !e_err;
    exp_addr = en ? ((e_addr / 4) % DEPTH) : 32'h0;
    chk("gnt", 32'({bus.dm_gnt, bus.im_gnt, bus.ext_gnt}), 32'({e_win == 1, e_win == 2, e_win == 3}));
    chk("sram_en", 32'(bus.sram_en), 32'(en));
    chk("sram_we_be", 32'({bus.sram_we, bus.sram_be}), e_wr ? 32'({1'b1, e_be}) : 32'h0);
    chk("sram_addr", 32'(bus.sram_addr), exp_addr);
    chk("sram_wdata", bus.sram_wdata, e_wr ? e_wdata : 32'h0);
    chk("rvalid", 32'({bus.dm_rvalid, bus.im_rvalid, bus.ext_rvalid}),
        32'({m_pend == 1, m_pend == 2, m_pend == 3}));
    chk("err", 32'({bus.dm_err, bus.im_err, bus.ext_err}),
        32'({m_pend == 1 && m_pend_err, m_pend == 2 && m_pend_err, m_pend == 3 && m_pend_err}));
    chk("rdata", bus.rdata, m_pend_data);
  endtask

  task automatic model_clear();
    m_pend = 0; m_pend_err = 0; m_pend_data = 0; m_starve = 0;
  endtask

  task automatic model_update();
    int idx;
    if (!resetb) begin
      model_clear();
    end else begin
      idx = int'(e_addr / 4);
      m_pend      = e_win;
      m_pend_err  = e_err;
      m_pend_data = 0;
      if (e_win != 0 && !e_err && !e_wr) m_pend_data = ref_mem[idx];
      if (e_wr)
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
      if (bus.ext_req && e_win != 3) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
    end
  endtask

  typedef struct {
    bit          dq, dw;
    logic [31:0] da;
    logic [3:0]  db;
    logic [31:0] dd;
    bit          iq;
    logic [31:0] ia;
    bit          eq;
    logic [31:0] ea;
    logic [2:0]  g;
    bit          en, we;
    logic [11:0] sa;
    logic [2:0]  rv, er;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(bit dq, bit dw, logic [31:0] da, logic [3:0] db, logic [31:0] dd,
                              bit iq, logic [31:0] ia, bit eq, logic [31:0] ea,
                              logic [2:0] g, bit en, bit we, logic [11:0] sa,
                              logic [2:0] rv, logic [2:0] er, logic [31:0] rd);
    vec_t v;
    v.dq = dq; v.dw = dw; v.da = da; v.db = db; v.dd = dd;
    v.iq = iq; v.ia = ia; v.eq = eq; v.ea = ea;
    v.g = g; v.en = en; v.we = we; v.sa = sa; v.rv = rv; v.er = er; v.rd = rd;
    return v;
  endfunction

  vec_t cur_row;
  bit   row_active = 0;

  task automatic row_check();
    chk("row_gnt", 32'({bus.dm_gnt, bus.im_gnt, bus.ext_gnt}), 32'(cur_row.g));
    chk("row_sram_en", 32'(bus.sram_en), 32'(cur_row.en));
    chk("row_sram_we", 32'(bus.sram_we), 32'(cur_row.we));
    chk("row_sram_addr", 32'(bus.sram_addr), 32'(cur_row.sa));
    chk("row_rvalid", 32'({bus.dm_rvalid, bus.im_rvalid, bus.ext_rvalid}), 32'(cur_row.rv));
    chk("row_err", 32'({bus.dm_err, bus.im_err, bus.ext_err}), 32'(cur_row.er));
    chk("row_rdata", bus.rdata, cur_row.rd);
  endtask

  task automatic chk_half();
    @(negedge clk);
    model_eval();
    model_check();
    if (row_active) row_check();
  endtask

  task automatic clk_half();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    chk_half();
    clk_half();
  endtask

  task automatic idle_inputs();
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    bus.im_req = 0; bus.im_addr = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0; bus.ext_be = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 19);
    a = 32'($urandom_range(0, 15)) << 2;
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  vec_t tbl[$];
  int   last_win;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    model_clear();
    idle_inputs();

    // Reset state, including a request that must not be granted during reset.
    cycle();
    bus.dm_req = 1; bus.dm_addr = 32'h10;
    cycle();
    idle_inputs();
    cycle();
    resetb = 1;
    for (int i = 0; i < 10; i++) begin
      chk_half();
      chk("idle_sram_en", 32'(bus.sram_en), 32'h0);
      clk_half();
    end

    //             dq dw da            db    dd            iq ia          eq ea     g       en we sa      rv      er      rd
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(1, 1, 32'h10,       4'hF, 32'hDEADBEEF, 0, 32'h0,  0, 32'h0,  3'b100, 1, 1, 12'h4, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,       4'hF, 32'h0,        0, 32'h0,  0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b100, 3'b000, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,       4'hF, 32'h0,        1, 32'h10, 0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b100, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 32'h10,       4'hF, 32'h0,        1, 32'h10, 0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b100, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 32'h10,       4'hF, 32'h0,        1, 32'h10, 0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b100, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h10, 0, 32'h0,  3'b010, 1, 0, 12'h4, 3'b100, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b010, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h2,  0, 32'h0,  3'b010, 0, 0, 12'h0, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(1, 0, 32'h40000000, 4'hF, 32'h0,        0, 32'h0,  0, 32'h0,  3'b100, 0, 0, 12'h0, 3'b010, 3'b010, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b100, 3'b100, 32'h0));
    tbl.push_back(mk(1, 1, 32'h10,       4'h0, 32'h12345678, 0, 32'h0,  0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b100, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  1, 32'h10, 3'b001, 1, 0, 12'h4, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b001, 3'b000, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 32'h10,       4'h3, 32'h0000CAFE, 0, 32'h0,  0, 32'h0,  3'b100, 1, 1, 12'h4, 3'b000, 3'b000, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,       4'hF, 32'h0,        0, 32'h0,  0, 32'h0,  3'b100, 1, 0, 12'h4, 3'b100, 3'b000, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        4'h0, 32'h0,        0, 32'h0,  0, 32'h0,  3'b000, 0, 0, 12'h0, 3'b100, 3'b000, 32'hDEADCAFE));

    row_active = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      cur_row = tbl[i];
      idle_inputs();
      bus.dm_req = cur_row.dq; bus.dm_we = cur_row.dw; bus.dm_addr = cur_row.da;
      bus.dm_be = cur_row.db; bus.dm_wdata = cur_row.dd;
      bus.im_req = cur_row.iq; bus.im_addr = cur_row.ia;
      bus.ext_req = cur_row.eq; bus.ext_addr = cur_row.ea;
      cycle();
    end
    row_active = 0;
    idle_inputs();
    cycle();

    // Loader starved by a continuous data stream: forced grant every STARVE_MAX+1 cycles.
    bus.dm_req = 1; bus.dm_addr = 32'h10; bus.dm_be = 4'hF;
    bus.ext_req = 1; bus.ext_addr = 32'h14;
    for (int i = 0; i < 10; i++) begin
      chk_half();
      chk("starve_ext_gnt", 32'(bus.ext_gnt), 32'(i == 4 || i == 9));
      chk("starve_dm_gnt", 32'(bus.dm_gnt), 32'(!(i == 4 || i == 9)));
      clk_half();
    end
    idle_inputs();
    cycle();

    // Reset one cycle after a loader read grant drops the pending response.
    bus.ext_req = 1; bus.ext_addr = 32'h10;
    chk_half();
    chk("rst_ext_gnt", 32'(bus.ext_gnt), 32'h1);
    clk_half();
    idle_inputs();
    bus.dm_req = 1; bus.dm_addr = 32'h10;
    resetb = 0;
    model_clear();
    chk_half();
    chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'h0);
    chk("rst_dm_gnt", 32'(bus.dm_gnt), 32'h0);
    clk_half();
    idle_inputs();
    resetb = 1;
    for (int i = 0; i < 3; i++) begin
      chk_half();
      chk("post_rst_ext_rvalid", 32'(bus.ext_rvalid), 32'h0);
      clk_half();
    end

    // Randomized traffic; each request is held until granted.
    last_win = 0;
    for (int n = 0; n < 600; n++) begin
      if (!bus.dm_req || last_win == 1) begin
        bus.dm_req = ($urandom_range(0, 3) != 0);
        bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_addr = rnd_addr();
        bus.dm_be = 4'($urandom); bus.dm_wdata = $urandom;
      end
      if (!bus.im_req || last_win == 2) begin
        bus.im_req = ($urandom_range(0, 1) != 0);
        bus.im_addr = rnd_addr();
      end
      if (!bus.ext_req || last_win == 3) begin
        bus.ext_req = ($urandom_range(0, 1) != 0);
        bus.ext_we = 1'($urandom_range(0, 1)); bus.ext_addr = rnd_addr();
        bus.ext_be = 4'($urandom); bus.ext_wdata = $urandom;
      end
      cycle();
      last_win = e_win;
    end
    idle_inputs();
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
